// File: rtl/portal_arb_pkg.sv
// Shared definitions for the portal indication arbiter.
//   arb_state_e : arbiter FSM states (IDLE, HDR, BODY)
//   LEN_LSB     : bit position of the length field inside a header word
//   rr_pick     : cyclic priority encoder, first set bit at or after a pointer
package portal_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY
    } arb_state_e;

    localparam int LEN_LSB     = 0;
    localparam int MAX_PORTALS = 16;
    localparam int PICK_IDX_W  = 4;

    typedef struct packed {
        logic                  any;
        logic [PICK_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scanning from the far end toward the pointer means the closest hit
    // is written last and therefore wins, without needing a found flag.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_PORTALS-1:0] pend,
        input logic [PICK_IDX_W-1:0]  ptr,
        input int                     numPortals
    );
        rr_pick_t   result;
        logic [4:0] idx;
        result = '0;
        for (int k = MAX_PORTALS - 1; k >= 0; k--) begin
            if (k < numPortals) begin
                idx = {1'b0, ptr} + 5'(k);
                if (idx >= 5'(numPortals)) begin
                    idx = idx - 5'(numPortals);
                end
                if (pend[idx[3:0]]) begin
                    result.any = 1'b1;
                    result.idx = idx[3:0];
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/portal_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   pend_i  : request vector, one bit per portal
//   ptr_i   : index with highest priority this cycle
//   grant_o : first requesting index at or after ptr_i (cyclic)
//   any_o   : at least one request present
module portal_arb_rr_pick
    import portal_arb_pkg::*;
#(
    parameter  int NUM_PORTALS = 4,
    localparam int CH_W        = $clog2(NUM_PORTALS)
) (
    input  logic [NUM_PORTALS-1:0] pend_i,
    input  logic [CH_W-1:0]        ptr_i,
    output logic [CH_W-1:0]        grant_o,
    output logic                   any_o
);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_PORTALS'(pend_i), PICK_IDX_W'(ptr_i), NUM_PORTALS);
        grant_o = CH_W'(pick.idx);
        any_o   = pick.any;
    end

endmodule

// File: rtl/portal_indication_arbiter.sv
// Shares one host indication read channel among NUM_PORTALS portals.
// One portal is granted round-robin and keeps the grant for a whole message
// (header word carrying the length, then body words).
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   ind_notEmpty / ind_first : per-portal FIFO status and head word
//   ind_deq                  : per-portal dequeue strobe (one-hot or zero)
//   cfg_enable               : per-portal arbitration / interrupt enable
//   host_valid/ready/data    : host read channel, plus host_channel and host_last
//   intr_status/intr_channel : registered interrupt summary (lowest pending index + 1)
//   msg_count                : completed messages, wraps
//   wdog_error               : sticky stall abort flag
// Optional feature: define PORTAL_ARB_WATCHDOG_EN to abort messages that stall
// for WDOG_CYCLES cycles; otherwise wdog_error is constant 0.
module portal_indication_arbiter
    import portal_arb_pkg::*;
#(
    parameter  int NUM_PORTALS = 4,
    parameter  int DATA_W      = 32,
    parameter  int LEN_W       = 16,
    parameter  int WDOG_CYCLES = 256,
    localparam int CH_W        = $clog2(NUM_PORTALS)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_PORTALS-1:0]        ind_notEmpty,
    input  logic [NUM_PORTALS*DATA_W-1:0] ind_first,
    output logic [NUM_PORTALS-1:0]        ind_deq,
    input  logic [NUM_PORTALS-1:0]        cfg_enable,
    output logic                          host_valid,
    input  logic                          host_ready,
    output logic [DATA_W-1:0]             host_data,
    output logic [CH_W-1:0]               host_channel,
    output logic                          host_last,
    output logic                          intr_status,
    output logic [31:0]                   intr_channel,
    output logic [31:0]                   msg_count,
    output logic                          wdog_error
);

    arb_state_e             state_q, state_d;
    logic [CH_W-1:0]        grant_q, grant_d;
    logic [CH_W-1:0]        rrPtr_q, rrPtr_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [31:0]            msgCount_q;
    logic                   intrStatus_q;
    logic [31:0]            intrChannel_q;

    logic [NUM_PORTALS-1:0] pend;
    logic [CH_W-1:0]        pickIdx, lowIdx, nextPtr;
    logic                   pickAny, lowAny;
    logic                   xfer, msgDone, stallHit, lenIsOne;
    logic [LEN_W-1:0]       hdrLen;

    assign pend = ind_notEmpty & cfg_enable;

    portal_arb_rr_pick #(.NUM_PORTALS(NUM_PORTALS)) u_pickRr (
        .pend_i  (pend),
        .ptr_i   (rrPtr_q),
        .grant_o (pickIdx),
        .any_o   (pickAny)
    );

    // Fixed pointer of zero yields the lowest pending index for the interrupt.
    portal_arb_rr_pick #(.NUM_PORTALS(NUM_PORTALS)) u_pickLow (
        .pend_i  (pend),
        .ptr_i   ('0),
        .grant_o (lowIdx),
        .any_o   (lowAny)
    );

    assign host_valid   = (state_q != IDLE) && ind_notEmpty[grant_q];
    assign host_data    = ind_first[int'(grant_q) * DATA_W +: DATA_W];
    assign host_channel = grant_q;
    assign xfer         = host_valid && host_ready;
    assign ind_deq      = xfer ? (NUM_PORTALS'(1) << grant_q) : '0;
    assign hdrLen       = host_data[LEN_LSB +: LEN_W];
    assign lenIsOne     = (hdrLen <= LEN_W'(1));
    assign nextPtr      = (grant_q == CH_W'(NUM_PORTALS - 1)) ? '0 : grant_q + CH_W'(1);
    assign msg_count    = msgCount_q;
    assign intr_status  = intrStatus_q;
    assign intr_channel = intrChannel_q;

    // A zero-length header still occupies one word, so it ends the message.
    always_comb begin
        host_last = 1'b0;
        if (host_valid) begin
            case (state_q)
                HDR:     host_last = lenIsOne;
                BODY:    host_last = (rem_q == LEN_W'(1));
                default: host_last = 1'b0;
            endcase
        end
    end

    // Message sequencing; completion and watchdog abort both release the grant
    // and move the round-robin pointer past the portal just served.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rrPtr_d = rrPtr_q;
        rem_d   = rem_q;
        msgDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    grant_d = pickIdx;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    if (lenIsOne) begin
                        msgDone = 1'b1;
                    end else begin
                        rem_d   = hdrLen - LEN_W'(1);
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                if (xfer) begin
                    if (rem_q == LEN_W'(1)) begin
                        msgDone = 1'b1;
                    end else begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (msgDone || stallHit) begin
            state_d = IDLE;
            rrPtr_d = nextPtr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rrPtr_q       <= '0;
            rem_q         <= '0;
            msgCount_q    <= '0;
            intrStatus_q  <= 1'b0;
            intrChannel_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rrPtr_q       <= rrPtr_d;
            rem_q         <= rem_d;
            if (msgDone) begin
                msgCount_q <= msgCount_q + 32'd1;
            end
            intrStatus_q  <= lowAny;
            intrChannel_q <= lowAny ? (32'(lowIdx) + 32'd1) : 32'd0;
        end
    end

`ifdef PORTAL_ARB_WATCHDOG_EN
    logic [31:0] stall_q, stall_d;
    logic        wdogError_q;

    assign stallHit   = (state_q != IDLE) && !host_valid && (stall_q == 32'(WDOG_CYCLES - 1));
    assign wdog_error = wdogError_q;

    // Only cycles with nothing to present count; host backpressure holds the count.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) || xfer || stallHit) begin
            stall_d = '0;
        end else if (!host_valid) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q     <= '0;
            wdogError_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            if (stallHit) begin
                wdogError_q <= 1'b1;
            end
        end
    end
`else
    assign stallHit = 1'b0;
    // Always 0; the comparison only keeps the stall-limit parameter referenced.
    assign wdog_error = (WDOG_CYCLES < 0);
`endif

endmodule
